// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave receive path.
package spi_slave_pkg;

  localparam logic [1:0] SPI_STD     = 2'b00;
  localparam logic [1:0] SPI_QUAD_TX = 2'b01;
  localparam logic [1:0] SPI_QUAD_RX = 2'b10;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_rx_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Generic synchronous FIFO for received words.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module spi_rx_fifo #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic              empty_o,
  output logic [WORD_W-1:0] data_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]     wr_q, rd_q;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // A push into a full FIFO is legal only alongside a pop.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_slave_rx_sampler.sv
// SPI slave receive front-end: oversamples the SPI pins in the clk_i domain,
// deserialises std/quad MOSI data MSB first and queues whole words.
module spi_slave_rx_sampler
  import spi_slave_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_csn_i,
  input  logic [3:0]        spi_sdi_i,
  input  logic [1:0]        spi_mode_i,
  output logic [WORD_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              abort_o,
  output logic              overflow_o,
  input  logic              ovf_clr_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  // Two-flop synchronisers plus a history stage for edge detection
  logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic       csn_s1_q, csn_s2_q, csn_s3_q;
  logic [3:0] sdi_s1_q, sdi_s2_q;

  logic       sclk_rise_c, csn_fall_c, csn_rise_c;
  logic       sclk_rise_q, csn_fall_q, csn_rise_q;
  logic [3:0] sdi_q;

  spi_rx_state_e     state_q, state_d;
  logic              quad_q, quad_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_upd;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              push_q, push_d;
  logic              abort_q, abort_d;
  logic              ovf_q, ovf_d;

  logic              fifo_full, fifo_empty, fifo_pop, drop_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      csn_s1_q  <= 1'b1;
      csn_s2_q  <= 1'b1;
      csn_s3_q  <= 1'b1;
      sdi_s1_q  <= '0;
      sdi_s2_q  <= '0;
    end else begin
      sclk_s1_q <= spi_sclk_i;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      csn_s1_q  <= spi_csn_i;
      csn_s2_q  <= csn_s1_q;
      csn_s3_q  <= csn_s2_q;
      sdi_s1_q  <= spi_sdi_i;
      sdi_s2_q  <= sdi_s1_q;
    end
  end

  assign sclk_rise_c = sclk_s2_q & ~sclk_s3_q;
  assign csn_fall_c  = ~csn_s2_q & csn_s3_q;
  assign csn_rise_c  = csn_s2_q & ~csn_s3_q;

  // Edge strobes are registered together with the matching data sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_rise_q <= 1'b0;
      csn_fall_q  <= 1'b0;
      csn_rise_q  <= 1'b0;
      sdi_q       <= '0;
    end else begin
      sclk_rise_q <= sclk_rise_c;
      csn_fall_q  <= csn_fall_c;
      csn_rise_q  <= csn_rise_c;
      sdi_q       <= sdi_s2_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      quad_q  <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      push_q  <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quad_q  <= quad_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      push_q  <= push_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
    end
  end

  // Frame FSM: shift on sclk edges, emit full words, flag partial frames
  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    push_d  = 1'b0;
    abort_d = 1'b0;
    cnt_upd = cnt_q;

    case (state_q)
      IDLE: begin
        if (csn_fall_q) begin
          state_d = SHIFT;
          quad_d  = (spi_mode_i == SPI_QUAD_RX);
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise_q) begin
          if (quad_q) begin
            shreg_d = {shreg_q[WORD_W-5:0], sdi_q};
            cnt_upd = cnt_q + CNT_W'(4);
          end else begin
            shreg_d = {shreg_q[WORD_W-2:0], sdi_q[0]};
            cnt_upd = cnt_q + CNT_W'(1);
          end
          if (cnt_upd == CNT_W'(WORD_W)) begin
            push_d = 1'b1;
            word_d = shreg_d;
            cnt_d  = '0;
          end else begin
            cnt_d  = cnt_upd;
          end
        end
        if (csn_rise_q) begin
          state_d = IDLE;
          abort_d = (cnt_d != '0);
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop = rx_valid_o && rx_ready_i;
  assign drop_c   = push_q && fifo_full && !fifo_pop;

  // A drop in the clear cycle wins over the clear
  always_comb begin
    ovf_d = ovf_q;
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  spi_rx_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_q),
    .data_i  (word_q),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .empty_o (fifo_empty),
    .data_o  (rx_data_o)
  );

  assign rx_valid_o = !fifo_empty;
  assign abort_o    = abort_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q == SHIFT);

endmodule
